// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared state encodings and widths for the instruction cache
package inst_cache_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, FILLED} state_t;
  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int OFF_W = 2;
  localparam int LADDR_W = 28;
endpackage

// File: rtl/inst_cache_array.sv
// inst_cache_array: valid/tag/data storage, combinational hit and word read, synchronous line write
module inst_cache_array
  import inst_cache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LADDR_W+OFF_W-1:0]   rd_addr,
  input  logic                       wr_en,
  input  logic [LADDR_W-1:0]         wr_addr,
  input  logic [LINE_W-1:0]          wr_data,
  output logic                       hit,
  output logic [WORD_W-1:0]          rdata
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = LADDR_W - IW;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0] tags [NUM_LINES];
  logic [LINE_W-1:0] data [NUM_LINES];
  logic [IW-1:0] ridx, widx;
  logic [TW-1:0] rtag, wtag;
  logic [LINE_W-1:0] line;
  assign ridx = rd_addr[OFF_W +: IW];
  assign rtag = rd_addr[OFF_W+IW +: TW];
  assign widx = wr_addr[IW-1:0];
  assign wtag = wr_addr[IW +: TW];
  assign line = data[ridx];
  assign hit = valid[ridx] && tags[ridx] == rtag;
  assign rdata = line[{rd_addr[OFF_W-1:0], 5'd0} +: WORD_W];
  // valid bits are the only reset state; a refill marks its line present
  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (wr_en) valid[widx] <= 1'b1;
  end
  // tag and data are written with the refill line and never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[widx] <= wtag;
      data[widx] <= wr_data;
    end
  end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache; ICACHE_PERF_CNT_EN adds hit/miss counters
module inst_cache
  import inst_cache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                proc_ren,
  input  logic                proc_wen,
  input  logic [29:0]         proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic [31:0]         proc_rdata,
  output logic                proc_stall,
  output logic                mem_ren,
  output logic                mem_wen,
  output logic [27:0]         mem_addr,
  output logic [127:0]        mem_wdata,
  input  logic [127:0]        mem_rdata,
`ifdef ICACHE_PERF_CNT_EN
  input  logic                mem_ready,
  output logic [31:0]         perf_hit,
  output logic [31:0]         perf_miss
`else
  input  logic                mem_ready
`endif
);
  state_t state;
  logic [LADDR_W-1:0] miss_addr;
  logic hit, miss, fill, lookup;
  logic [WORD_W-1:0] word;
  logic unused;
  assign unused = ^proc_wdata ^ (WORDS_PER_LINE != 4);
  assign lookup = state != FETCH;
  assign miss = proc_ren && !proc_wen && !hit;
  assign fill = state == FETCH && mem_ready && !rst;
  assign proc_stall = !lookup || miss;
  assign proc_rdata = hit ? word : '0;
  assign mem_ren = state == FETCH;
  assign mem_addr = miss_addr;
  assign mem_wen = 1'b0;
  assign mem_wdata = '0;
  inst_cache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk(clk), .rst(rst), .rd_addr(proc_addr), .wr_en(fill),
    .wr_addr(miss_addr), .wr_data(mem_rdata), .hit(hit), .rdata(word)
  );
  // FILLED behaves like IDLE for the held request; FETCH waits only for mem_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      miss_addr <= '0;
    end else if (!lookup) state <= mem_ready ? FILLED : FETCH;
    else if (miss) begin
      state <= FETCH;
      miss_addr <= proc_addr[29:2];
    end else state <= IDLE;
  end
`ifdef ICACHE_PERF_CNT_EN
  // counters sample only lookup cycles, so stalled FETCH cycles never count
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit <= '0;
      perf_miss <= '0;
    end else begin
      perf_hit <= perf_hit + 32'(lookup && proc_ren && hit);
      perf_miss <= perf_miss + 32'(lookup && miss);
    end
  end
`endif
endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: directed scoreboard bench for inst_cache
module tb_inst_cache;
  logic clk = 0, rst = 1, proc_ren = 0, proc_wen = 0, mem_ready = 0;
  logic [29:0] proc_addr = 0;
  logic [31:0] proc_wdata = 32'hdead_beef, proc_rdata;
  logic proc_stall, mem_ren, mem_wen;
  logic [27:0] mem_addr;
  logic [127:0] mem_wdata, mem_rdata = 0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit, perf_miss;
`endif
  logic [127:0] q[$];
  int checks = 0, errors = 0;
  inst_cache dut (
    .clk(clk), .rst(rst), .proc_ren(proc_ren), .proc_wen(proc_wen),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ICACHE_PERF_CNT_EN
    .perf_hit(perf_hit), .perf_miss(perf_miss),
`endif
    .mem_ready(mem_ready)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic exp(input logic [127:0] v);
    q.push_back(v);
  endtask
  task automatic chk(input string tag, input logic [127:0] obs);
    logic [127:0] e;
    e = q.size() > 0 ? q.pop_front() : 'x;
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask
  function automatic logic [127:0] mk(input logic [31:0] w3, w2, w1, w0);
    return {w3, w2, w1, w0};
  endfunction
  task automatic refill(input logic [27:0] a, input logic [127:0] l);
    int n = 0;
    while (!mem_ren && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp(1); chk("fetch_wait", mem_ren);
    exp(a); chk("fetch_addr", mem_addr);
    cyc();
    mem_ready = 1;
    mem_rdata = l;
    cyc();
    mem_ready = 0;
    @(negedge clk);
  endtask
  initial begin
    cyc(); cyc();
    rst = 0;
    @(negedge clk);
    exp(0); chk("rst_stall", proc_stall);
    exp(0); chk("rst_mem_ren", mem_ren);
    exp(0); chk("rst_mem_addr", mem_addr);
    exp(0); chk("rst_rdata", proc_rdata);
    exp(0); chk("mem_wen", mem_wen);
    exp(0); chk("mem_wdata", mem_wdata);
    // cold miss on word 5
    cyc(); proc_ren = 1; proc_addr = 30'h5;
    @(negedge clk);
    exp(1); chk("cold_stall", proc_stall);
    exp(0); chk("cold_no_req_yet", mem_ren);
    cyc(); @(negedge clk);
    exp(1); chk("cold_mem_ren", mem_ren);
    exp(1); chk("cold_mem_addr", mem_addr);
    exp(1); chk("cold_fetch_stall", proc_stall);
    cyc(); mem_ready = 1; mem_rdata = mk(4, 3, 2, 1);
    @(negedge clk);
    exp(1); chk("ready_cycle_stall", proc_stall);
    cyc(); mem_ready = 0;
    @(negedge clk);
    exp(0); chk("filled_stall", proc_stall);
    exp(2); chk("filled_rdata", proc_rdata);
    exp(0); chk("filled_mem_ren", mem_ren);
    // hit on same line
    cyc(); proc_addr = 30'h7;
    @(negedge clk);
    exp(0); chk("hit_stall", proc_stall);
    exp(4); chk("hit_rdata", proc_rdata);
    exp(0); chk("hit_mem_ren", mem_ren);
    // conflict eviction: line 0x09 aliases line 0x01
    cyc(); proc_addr = 30'h24;
    @(negedge clk);
    exp(1); chk("alias_stall", proc_stall);
    refill(28'h9, mk(32'h94, 32'h93, 32'h92, 32'h91));
    exp(32'h91); chk("alias_rdata", proc_rdata);
    cyc(); proc_addr = 30'h5;
    @(negedge clk);
    exp(1); chk("evicted_stall", proc_stall);
    refill(28'h1, mk(4, 3, 2, 1));
    exp(2); chk("refill_rdata", proc_rdata);
    // redirect during refill
    cyc(); proc_addr = 30'h10;
    @(negedge clk);
    exp(1); chk("redir_stall", proc_stall);
    cyc(); @(negedge clk);
    exp(4); chk("redir_mem_addr", mem_addr);
    cyc(); proc_addr = 30'h20; mem_ready = 1; mem_rdata = mk(32'h13, 32'h12, 32'h11, 32'h10);
    cyc(); mem_ready = 0;
    @(negedge clk);
    exp(1); chk("redir_new_miss", proc_stall);
    refill(28'h8, mk(32'h23, 32'h22, 32'h21, 32'h20));
    exp(32'h20); chk("redir_new_rdata", proc_rdata);
    cyc(); proc_addr = 30'h10;
    @(negedge clk);
    exp(0); chk("redir_old_hit", proc_stall);
    exp(32'h10); chk("redir_old_rdata", proc_rdata);
    // reset during FETCH
    cyc(); proc_addr = 30'h30;
    cyc(); @(negedge clk);
    exp(1); chk("rf_mem_ren", mem_ren);
    cyc(); rst = 1;
    cyc(); rst = 0; proc_ren = 0;
    @(negedge clk);
    exp(0); chk("rf_mem_ren_drop", mem_ren);
    exp(0); chk("rf_stall", proc_stall);
    cyc(); mem_ready = 1; mem_rdata = {4{32'hbad0_bad0}};
    cyc(); mem_ready = 0;
    @(negedge clk);
    exp(0); chk("rf_late_ready", mem_ren);
    cyc(); proc_ren = 1;
    @(negedge clk);
    exp(1); chk("rf_reread_miss", proc_stall);
    cyc(); rst = 1; proc_ren = 0;
    cyc(); rst = 0;
    // write request on empty cache
    proc_wen = 1; proc_addr = 30'h3;
    @(negedge clk);
    exp(0); chk("wen_stall", proc_stall);
    exp(0); chk("wen_mem_ren", mem_ren);
    cyc(); @(negedge clk);
    exp(0); chk("wen_mem_ren_later", mem_ren);
`ifdef ICACHE_PERF_CNT_EN
    exp(0); chk("wen_perf_miss", perf_miss);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
